// File: rtl/div_iter_pkg.sv
// Shared state encoding and constants for the iterative restoring divider.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Width of the {remainder, quotient} result bus.
  function automatic int div_bus_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: trial subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // partial_rem < 2*divisor always holds, so WIDTH+1 bits suffice and the MSB is the borrow.
  assign diff     = partial_rem - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign next_rem = q_bit ? diff[WIDTH-1:0] : partial_rem[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for EX: WIDTH+1 cycle latency, zero-divisor short-cut, annul.
// Signed operand support is built only when DIV_SIGNED_EN is defined.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_i,
  input  logic [WIDTH-1:0]        opdata1_i,
  input  logic [WIDTH-1:0]        opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [2*WIDTH-1:0]      result_o,
  output logic                    ready_o,
  output logic                    stallreq_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BUS_W = div_bus_w(WIDTH);

  div_state_e        state_q, state_d;
  logic [WIDTH-1:0]  dividend_q, divisor_q, rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BUS_W-1:0]  result_q;
  logic              accept, last_step;
  logic [WIDTH-1:0]  mag_a, mag_b, next_rem, quot_next, fix_quot, fix_rem;
  logic              q_bit;

  assign accept    = (state_q == DIV_FREE) && (start_i == DIV_START) && !annul_i;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem (({rem_q, dividend_q[WIDTH-1]})),
    .divisor     (divisor_q),
    .next_rem    (next_rem),
    .q_bit       (q_bit)
  );

  // Dividend register doubles as the quotient shift register.
  assign quot_next = {dividend_q[WIDTH-2:0], q_bit};

`ifdef DIV_SIGNED_EN
  logic sign_a, sign_b, neg_quot_q, neg_rem_q;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  assign sign_a   = signed_i & opdata1_i[WIDTH-1];
  assign sign_b   = signed_i & opdata2_i[WIDTH-1];
  assign mag_a    = sign_a ? twos_neg(opdata1_i) : opdata1_i;
  assign mag_b    = sign_b ? twos_neg(opdata2_i) : opdata2_i;
  assign fix_quot = neg_quot_q ? twos_neg(quot_next) : quot_next;
  assign fix_rem  = neg_rem_q ? twos_neg(next_rem) : next_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (accept) begin
      neg_quot_q <= sign_a ^ sign_b;
      neg_rem_q  <= sign_a;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign mag_a         = opdata1_i;
  assign mag_b         = opdata2_i;
  assign fix_quot      = quot_next;
  assign fix_rem       = next_rem;
`endif

  always_comb begin
    state_d    = state_q;
    stallreq_o = 1'b0;
    unique case (state_q)
      DIV_FREE: begin
        if (accept) begin
          stallreq_o = 1'b1;
          state_d    = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        stallreq_o = 1'b1;
        state_d    = annul_i ? DIV_FREE : DIV_END;
      end
      DIV_ON: begin
        stallreq_o = 1'b1;
        if (annul_i)        state_d = DIV_FREE;
        else if (last_step) state_d = DIV_END;
      end
      DIV_END: begin
        if (start_i == DIV_STOP) state_d = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_FREE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        DIV_FREE: begin
          if (accept) begin
            dividend_q <= mag_a;
            divisor_q  <= mag_b;
            rem_q      <= '0;
            cnt_q      <= '0;
          end
        end
        DIV_BY_ZERO: begin
          if (!annul_i) result_q <= '0;
        end
        DIV_ON: begin
          if (!annul_i) begin
            rem_q      <= next_rem;
            dividend_q <= quot_next;
            cnt_q      <= cnt_q + 1'b1;
            if (last_step) result_q <= {fix_rem, fix_quot};
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign result_o = ready_o ? result_q : '0;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter (WIDTH=32) against a plain-arithmetic division model.
module tb_div_iter;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          signed_in = 1'b0;
  logic [W-1:0]  opdata1 = '0;
  logic [W-1:0]  opdata2 = '0;
  logic          start = 1'b0;
  logic          annul = 1'b0;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          stallreq_o;

  int n_tests = 0;
  int n_fail  = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .signed_i   (signed_in),
    .opdata1_i  (opdata1),
    .opdata2_i  (opdata2),
    .start_i    (start),
    .annul_i    (annul),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    longint sa, sb, q, r;
    logic [W-1:0] uq, ur;
    if (b == '0) return '0;
    if (s && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[W-1:0], q[W-1:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [2*W-1:0] res, output int lat, output int stall,
                        output bit ok);
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_in = s; start = 1'b1;
    lat = 0; stall = 0; ok = 1'b0;
    while (lat < 100) begin
      #1;
      if (ready_o) begin ok = 1'b1; break; end
      if (stallreq_o) stall++;
      @(negedge clk);
      lat++;
    end
    res = result_o;
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    n_tests++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stallreq_o); end
    n_tests++; if (result_o !== '0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result_o); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2*W-1:0] res; int lat, stall; bit ok;
    do_div(32'd100, 32'd7, 1'b0, res, lat, stall, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL div100_7_timeout lat=%0d", lat); end
    n_tests++; if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL div100_7 got=%h exp=%h", res, {32'd2, 32'd14}); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL div100_7_latency got=%0d exp=33", lat); end
    n_tests++; if (stall !== 33) begin n_fail++; $display("FAIL div100_7_stall got=%0d exp=33", stall); end
    n_tests++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL end_stall got=%b exp=0", stallreq_o); end
    drop_start();
    n_tests++; if (ready_o !== 1'b0 || result_o !== '0) begin n_fail++; $display("FAIL after_drop ready=%b result=%h exp 0/0", ready_o, result_o); end

    do_div(32'd5, 32'd0, 1'b0, res, lat, stall, ok);
    n_tests++; if (!ok || res !== '0) begin n_fail++; $display("FAIL div_by_zero got=%h ok=%0d exp=0", res, ok); end
    n_tests++; if (lat !== 2 || stall !== 2) begin n_fail++; $display("FAIL div_by_zero_timing lat=%0d stall=%0d exp=2/2", lat, stall); end
    drop_start();

    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, res, lat, stall, ok);
    n_tests++; if (res !== {32'h0000_0001, 32'h7FFF_FFFC}) begin n_fail++; $display("FAIL neg7_div2_unsigned got=%h exp=%h", res, {32'h1, 32'h7FFF_FFFC}); end
    drop_start();

    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, res, lat, stall, ok);
    n_tests++; if (res !== model(32'hFFFF_FFF9, 32'd2, 1'b1)) begin n_fail++; $display("FAIL neg7_div2_signed got=%h exp=%h", res, model(32'hFFFF_FFF9, 32'd2, 1'b1)); end
    if (SIGNED_EN) begin
      n_tests++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL neg7_div2_signed_const got=%h exp=ffffffff_fffffffd", res); end
    end
    drop_start();

    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, stall, ok);
    n_tests++; if (res !== model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1)) begin n_fail++; $display("FAIL most_neg_div_m1 got=%h exp=%h", res, model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1)); end
    drop_start();
  endtask

  task automatic test_random();
    logic [2*W-1:0] res, exp_res; int lat, stall; bit ok;
    logic [W-1:0] a, b; logic s;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = '0;
        3: b = 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      s = 1'($urandom_range(0, 1));
      exp_res = model(a, b, s);
      do_div(a, b, s, res, lat, stall, ok);
      n_tests++;
      if (!ok || res !== exp_res || lat !== ((b == '0) ? 2 : 33)) begin
        n_fail++;
        $display("FAIL random a=%h b=%h s=%0d got=%h lat=%0d exp=%h", a, b, s, res, lat, exp_res);
      end
      drop_start();
    end
  endtask

  task automatic test_annul();
    logic [2*W-1:0] res; int lat, stall; bit ok; bit saw_ready;
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_in = 1'b0; start = 1'b1;
    @(negedge clk);
    repeat (9) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    #1;
    n_tests++; if (stallreq_o !== 1'b1) begin n_fail++; $display("FAIL annul_busy_stall got=%b exp=1", stallreq_o); end
    @(negedge clk);
    annul = 1'b0;
    #1;
    n_tests++; if (stallreq_o !== 1'b0 || ready_o !== 1'b0) begin n_fail++; $display("FAIL annul_free stall=%b ready=%b exp 0/0", stallreq_o, ready_o); end
    saw_ready = 1'b0;
    repeat (40) begin @(negedge clk); saw_ready |= ready_o; end
    n_tests++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL annul_no_ready got=%b exp=0", saw_ready); end
    do_div(32'd9, 32'd3, 1'b0, res, lat, stall, ok);
    n_tests++; if (!ok || res !== {32'd0, 32'd3} || lat !== 33) begin n_fail++; $display("FAIL after_annul got=%h lat=%0d exp=%h/33", res, lat, {32'd0, 32'd3}); end
    drop_start();
  endtask

  task automatic test_hold_start();
    logic [2*W-1:0] res, exp_res; int lat, stall; bit ok;
    exp_res = model(32'd50, 32'd6, 1'b0);
    do_div(32'd50, 32'd6, 1'b0, res, lat, stall, ok);
    n_tests++; if (!ok || res !== exp_res) begin n_fail++; $display("FAIL hold_first got=%h exp=%h", res, exp_res); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (ready_o !== 1'b1 || result_o !== exp_res || stallreq_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d ready=%b result=%h exp 1/%h", i, ready_o, result_o, exp_res);
      end
    end
    drop_start();
    #1;
    n_tests++; if (ready_o !== 1'b0 || result_o !== '0) begin n_fail++; $display("FAIL hold_release ready=%b result=%h exp 0/0", ready_o, result_o); end
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] res; int lat, stall; bit ok;
    @(negedge clk);
    opdata1 = 32'd12345; opdata2 = 32'd11; signed_in = 1'b0; start = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b0; start = 1'b0;
    #1;
    n_tests++;
    if (ready_o !== 1'b0 || stallreq_o !== 1'b0 || result_o !== '0) begin
      n_fail++;
      $display("FAIL reset_mid ready=%b stall=%b result=%h exp all 0", ready_o, stallreq_o, result_o);
    end
    @(negedge clk); rst = 1'b1;
    do_div(32'd77, 32'd5, 1'b0, res, lat, stall, ok);
    n_tests++; if (!ok || res !== {32'd2, 32'd15} || lat !== 33) begin n_fail++; $display("FAIL after_reset got=%h lat=%0d exp=%h/33", res, lat, {32'd2, 32'd15}); end
    drop_start();
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] res; int lat, stall; bit ok;
    do_div(32'hDEAD_BEEF, 32'h1234, 1'b0, res, lat, stall, ok);
    n_tests++; if (res !== model(32'hDEAD_BEEF, 32'h1234, 1'b0)) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", res, model(32'hDEAD_BEEF, 32'h1234, 1'b0)); end
    start = 1'b0;
    do_div(32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b1, res, lat, stall, ok);
    n_tests++; if (!ok || res !== model(32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b1) || lat !== 33) begin n_fail++; $display("FAIL b2b_second got=%h lat=%0d exp=%h", res, lat, model(32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b1)); end
    drop_start();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_hold_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
